// File: rtl/field_merge_engine.sv
// Sequential piece-to-field merge: walks the rotated piece one cell per clock.
// Optional row compaction after an accepted commit: FIELD_MERGE_ROW_CLEAR_EN.
module field_merge_engine #(
  parameter int FIELD_W = 20,
  parameter int FIELD_H = 20,
  parameter int PIECE_N = 4,
  parameter int POS_W   = 5,
  parameter int LC_W    = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       mode,
  input  logic [POS_W-1:0]           block_pos_x,
  input  logic [POS_W-1:0]           block_pos_y,
  input  logic [1:0]                 rotate,
  input  logic [PIECE_N*PIECE_N-1:0] block_matrix,
  input  logic [FIELD_W*FIELD_H-1:0] field_background,
  output logic                       busy,
  output logic                       done,
  output logic                       collision,
  output logic                       out_of_bounds,
  output logic [FIELD_W*FIELD_H-1:0] field_out,
  output logic [LC_W-1:0]            lines_cleared
);
  localparam int FN  = FIELD_W * FIELD_H;
  localparam int PN  = PIECE_N * PIECE_N;
  localparam int IW  = (PN > 1) ? $clog2(PN) : 1;
  localparam int FIW = $clog2(FN);

`ifdef FIELD_MERGE_ROW_CLEAR_EN
  typedef enum logic [1:0] {IDLE, SCAN, CLEAR, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
`endif

  state_t           state;
  logic             mode_l;
  logic [POS_W-1:0] pos_x_l, pos_y_l;
  logic [1:0]       rot_l;
  logic [PN-1:0]    matrix_l;
  logic [FN-1:0]    bg_l, work, work_next;
  logic [IW-1:0]    idx;
  logic             coll_acc, oob_acc;

  int               bx_i, by_i, src_i;
  logic [POS_W:0]   fx, fy;
  logic             cell_set, in_field, cell_coll, scan_coll, scan_oob, reject;

  // One piece cell per cycle; coordinates carry an extra bit so the edge never wraps.
  always_comb begin
    bx_i = int'(idx) % PIECE_N;
    by_i = int'(idx) / PIECE_N;
    case (rot_l)
      2'd0:    src_i = by_i * PIECE_N + bx_i;
      2'd1:    src_i = (PIECE_N - 1 - bx_i) * PIECE_N + by_i;
      2'd2:    src_i = (PIECE_N - 1 - by_i) * PIECE_N + (PIECE_N - 1 - bx_i);
      default: src_i = bx_i * PIECE_N + (PIECE_N - 1 - by_i);
    endcase
    cell_set  = matrix_l[IW'(src_i)];
    fx        = {1'b0, pos_x_l} + (POS_W+1)'(bx_i);
    fy        = {1'b0, pos_y_l} + (POS_W+1)'(by_i);
    in_field  = (int'(fx) < FIELD_W) && (int'(fy) < FIELD_H);
    cell_coll = 1'b0;
    work_next = work;
    if (cell_set && in_field) begin
      cell_coll = work[FIW'(int'(fy) * FIELD_W + int'(fx))];
      work_next[FIW'(int'(fy) * FIELD_W + int'(fx))] = 1'b1;
    end
    scan_coll = coll_acc | cell_coll;
    scan_oob  = oob_acc | (cell_set && !in_field);
    reject    = mode_l && (scan_coll || scan_oob);
  end

`ifdef FIELD_MERGE_ROW_CLEAR_EN
  localparam int RW = $clog2(FIELD_H + 1);
  logic [RW-1:0]   rd_row, kept, kept_next;
  logic [LC_W-1:0] lc_acc, lc_next;
  logic [FN-1:0]   clr_next;
  logic            row_full;

  // Write row is FIELD_H-1-kept; rows above it are blanked on the final step.
  always_comb begin
    clr_next  = work;
    kept_next = kept;
    row_full  = &work[FIW'(int'(rd_row) * FIELD_W) +: FIELD_W];
    lc_next   = lc_acc + {{(LC_W-1){1'b0}}, row_full};
    if (!row_full) begin
      clr_next[FIW'((FIELD_H - 1 - int'(kept)) * FIELD_W) +: FIELD_W] =
        work[FIW'(int'(rd_row) * FIELD_W) +: FIELD_W];
      kept_next = kept + RW'(1);
    end
    if (rd_row == '0) begin
      for (int i = 0; i < FIELD_H; i++) begin
        if (i + int'(kept_next) < FIELD_H) clr_next[FIW'(i * FIELD_W) +: FIELD_W] = '0;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      collision     <= 1'b0;
      out_of_bounds <= 1'b0;
      field_out     <= '0;
      lines_cleared <= '0;
      mode_l        <= 1'b0;
      pos_x_l       <= '0;
      pos_y_l       <= '0;
      rot_l         <= '0;
      matrix_l      <= '0;
      bg_l          <= '0;
      work          <= '0;
      idx           <= '0;
      coll_acc      <= 1'b0;
      oob_acc       <= 1'b0;
`ifdef FIELD_MERGE_ROW_CLEAR_EN
      rd_row        <= '0;
      kept          <= '0;
      lc_acc        <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_l   <= mode;
          pos_x_l  <= block_pos_x;
          pos_y_l  <= block_pos_y;
          rot_l    <= rotate;
          matrix_l <= block_matrix;
          bg_l     <= field_background;
          work     <= field_background;
          idx      <= '0;
          coll_acc <= 1'b0;
          oob_acc  <= 1'b0;
          busy     <= 1'b1;
          state    <= SCAN;
        end
        SCAN: begin
          work     <= work_next;
          coll_acc <= scan_coll;
          oob_acc  <= scan_oob;
          idx      <= idx + IW'(1);
          if (idx == IW'(PN - 1)) begin
`ifdef FIELD_MERGE_ROW_CLEAR_EN
            if (mode_l && !reject) begin
              rd_row <= RW'(FIELD_H - 1);
              kept   <= '0;
              lc_acc <= '0;
              state  <= CLEAR;
            end else begin
              field_out     <= reject ? bg_l : work_next;
              collision     <= scan_coll;
              out_of_bounds <= scan_oob;
              lines_cleared <= '0;
              done          <= 1'b1;
              busy          <= 1'b0;
              state         <= DONE;
            end
`else
            field_out     <= reject ? bg_l : work_next;
            collision     <= scan_coll;
            out_of_bounds <= scan_oob;
            lines_cleared <= '0;
            done          <= 1'b1;
            busy          <= 1'b0;
            state         <= DONE;
`endif
          end
        end
`ifdef FIELD_MERGE_ROW_CLEAR_EN
        CLEAR: begin
          work   <= clr_next;
          kept   <= kept_next;
          lc_acc <= lc_next;
          rd_row <= rd_row - RW'(1);
          if (rd_row == '0) begin
            field_out     <= clr_next;
            collision     <= coll_acc;
            out_of_bounds <= oob_acc;
            lines_cleared <= lc_next;
            done          <= 1'b1;
            busy          <= 1'b0;
            state         <= DONE;
          end
        end
`endif
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/field_merge_engine.md
# field_merge_engine

Sequential, parametrised piece-to-field merge engine for the Tetris datapath. It sits between the game-control FSM and the display/background registers, and replaces the combinational per-cell merge. It walks the rotated PIECE_N×PIECE_N piece matrix one cell per clock, reporting collision and out-of-bounds conditions. It produces either a display overlay or a committed background, optionally followed by full-row clearing.

## Interface
- FIELD_W, 20: field columns (x).
- FIELD_H, 20: field rows (y); row 0 is the top row.
- PIECE_N, 4: piece matrix edge; the matrix has PIECE_N² bits.
- POS_W, 5: width of the piece position coordinates.
- LC_W, 5: width of lines_cleared; must be ≥ clog2(FIELD_H+1).
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a merge; sampled only in IDLE.
- mode  in  1  0 = display overlay, 1 = commit to background.
- block_pos_x, block_pos_y  in  POS_W  field coordinates of piece cell (0,0).
- rotate  in  2  rotation: 0/1/2/3 = 0°/90°/180°/270° clockwise.
- block_matrix  in  PIECE_N²  piece bits; bit by*PIECE_N+bx is cell (bx,by).
- field_background  in  FIELD_W*FIELD_H  background; bit fy*FIELD_W+fx is cell (fx,fy).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when results are valid.
- collision  out  1  a set piece cell landed on a set background cell.
- out_of_bounds  out  1  a set piece cell fell outside the field.
- field_out  out  FIELD_W*FIELD_H  result field; held until the next done.
- lines_cleared  out  LC_W  number of rows removed by the last commit.

## Operation
- FSM states: IDLE, SCAN, CLEAR (macro only), DONE.
- IDLE:
  - On start=1, latch mode, position, rotate, block_matrix and field_background into a working field.
  - Clear the collision/out_of_bounds accumulators, set idx=0 and go to SCAN.
- SCAN handles one cell per cycle for idx = 0 … PIECE_N²−1, with bx = idx mod PIECE_N and by = idx div PIECE_N.
- Source bit for cell (bx,by), with N = PIECE_N:
  - rot 0: by*N+bx
  - rot 1: (N−1−bx)*N+by
  - rot 2: (N−1−by)*N+(N−1−bx)
  - rot 3: bx*N+(N−1−by)
- If the source bit is set:
  - Compute fx = pos_x+bx and fy = pos_y+by in POS_W+1 bits, so there is no wrap.
  - If fx ≥ FIELD_W or fy ≥ FIELD_H: set out_of_bounds and write nothing.
  - Otherwise: if the working bit is already 1, set collision; then write 1 to the working bit.
- After the last idx:
  - mode=1 with collision or out_of_bounds: the commit is rejected, field_out = latched background, lines_cleared = 0.
  - Otherwise the working field is the result.
- Next state after SCAN: CLEAR if the macro is compiled in and the commit was accepted, else DONE.
- DONE, one cycle:
  - Register field_out, collision, out_of_bounds and lines_cleared.
  - Pulse done and return to IDLE.
- Display mode always overlays, including over collisions; in-bounds cells are still drawn when out_of_bounds is set.
- start while busy is ignored; no queueing.
- Reset value of every output is 0 (field_out all zeros).
- rst mid-operation aborts to IDLE, discards the working field, produces no done, and zeroes all outputs.

## Timing
- start is high in cycle 0.
- busy is high in cycles 1 … PIECE_N²(+FIELD_H with CLEAR), i.e. 1…16 or 1…36 with defaults.
- done pulses in cycle PIECE_N²+1, which is 17 with defaults.
- With CLEAR, done pulses in cycle PIECE_N²+FIELD_H+1, which is 37 with defaults.
- Outputs change only in the done cycle.
- busy falls in the same cycle done rises.
- A new start is accepted in the cycle after done.

## Configuration
- FIELD_MERGE_ROW_CLEAR_EN defined:
  - The CLEAR state compacts the field, one row per cycle, FIELD_H cycles.
  - A read pointer r runs from FIELD_H−1 down to 0; the write pointer w starts at FIELD_H−1.
  - If row r is full, increment lines_cleared. Otherwise copy row r to row w and decrement w.
  - Rows above the final w are zeroed.
  - Only entered on an accepted commit.
- FIELD_MERGE_ROW_CLEAR_EN undefined:
  - There is no CLEAR state and done always follows SCAN.
  - lines_cleared is tied to 0.

## Test plan
- Overlay placement:
  - Stimulus: defaults, mode=0, matrix 16'h0066, pos (0,0), rot 0, background 0.
  - Response: done at cycle 17; field_out bits 1, 2, 21, 22 set; collision=0.
- Rejected commit on collision:
  - Stimulus: as the overlay case, plus background bit 21 set, mode=1.
  - Response: collision=1; field_out equals background (only bit 21 set).
- Out of bounds:
  - Stimulus: matrix 16'h0002, pos (19,0), rot 0, mode=0.
  - Response: out_of_bounds=1; field_out = background; no wrap into bit 20.
- Rotation:
  - Stimulus: matrix 16'h0001, pos (5,5), rot 1.
  - Response: only bit 5*20+8 = 108 set.
- Row clear (macro on):
  - Stimulus: background row 19 set except column 0, plus bit 18*20+3; mode=1, matrix 16'h0001, pos (0,19).
  - Response: done at cycle 37; lines_cleared=1; field_out has only bit 19*20+3 = 383 set.
- Reset and start while busy:
  - Stimulus: rst pulsed at cycle 8 of a scan.
  - Response: no done; outputs 0; busy=0 next cycle.
  - Stimulus: start asserted during busy.
  - Response: ignored.
